// File: rtl/seg_pkg.sv
// Shared glyph encodings and message-state type for the doorlock 7-segment panel.
package seg_pkg;

    // Segment order is {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] GLY_O     = 7'b1111110;
    localparam logic [6:0] GLY_P     = 7'b1100111;
    localparam logic [6:0] GLY_E     = 7'b1001111;
    localparam logic [6:0] GLY_N     = 7'b0010101;
    localparam logic [6:0] GLY_R     = 7'b0000101;
    localparam logic [6:0] GLY_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        ERR  = 2'd2
    } msg_state_t;

    // Glyph ROM: message text is left-justified, digits past the text are blank.
    function automatic logic [6:0] glyph_for(msg_state_t st, int unsigned digit, logic blink_on);
        logic [6:0] g;
        g = GLY_BLANK;
        case (st)
            OPEN: begin
                case (digit)
                    0:       g = GLY_O;
                    1:       g = GLY_P;
                    2:       g = GLY_E;
                    3:       g = GLY_N;
                    default: g = GLY_BLANK;
                endcase
            end
            ERR: begin
                if (blink_on) begin
                    case (digit)
                        0:       g = GLY_E;
                        1:       g = GLY_R;
                        2:       g = GLY_R;
                        default: g = GLY_BLANK;
                    endcase
                end
            end
            default: g = GLY_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit-scan timebase: free-running prescaler producing scan_tick and the active digit index.
module seg_scan_timer #(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned IDX_W      = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             scan_tick_o,
    output logic [IDX_W-1:0] idx_o
);

    localparam int unsigned      PW        = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]    PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tick;

    assign tick        = (presc_q == PRESC_MAX);
    assign scan_tick_o = tick;
    assign idx_o       = idx_q;

    // Next prescaler count and digit index; the index moves only on a wrap.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
    end

    // Timebase registers, running in every display state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/seg_msg_scan.sv
// Doorlock front-panel message engine: OPEn (steady) / Err (blinking) with hold timeout.
module seg_msg_scan
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned SCAN_DIV    = 1000,
    parameter int unsigned HOLD_SCANS  = 4000,
    parameter int unsigned BLINK_SCANS = 500,
    parameter bit          COM_ACT_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  show_open,
    input  logic                  show_err,
    input  logic                  cancel,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] com,
    output logic                  busy
);

    localparam int unsigned IDX_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
    localparam int unsigned HW    = (HOLD_SCANS  > 1) ? $clog2(HOLD_SCANS)  : 1;
    localparam int unsigned BW    = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    localparam logic [HW-1:0]         HOLD_MAX  = HW'(HOLD_SCANS - 1);
    localparam logic [BW-1:0]         BLINK_MAX = BW'(BLINK_SCANS - 1);
    localparam logic [NUM_DIGITS-1:0] COM_IDLE  = {NUM_DIGITS{COM_ACT_LOW}};

    logic             scan_tick;
    logic [IDX_W-1:0] idx_q;

    msg_state_t state_q, state_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [BW-1:0]  blink_q, blink_d;
    logic           blink_on_q, blink_on_d;

    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] com_q, com_d;
    logic                  busy_q, busy_d;

    seg_scan_timer #(
        .SCAN_DIV   (SCAN_DIV),
        .NUM_DIGITS (NUM_DIGITS),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk_i       (clk),
        .rst_i       (rst),
        .scan_tick_o (scan_tick),
        .idx_o       (idx_q)
    );

    // Message FSM: cancel > show_err > show_open > hold expiry; pulses retrigger the hold.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        blink_d    = blink_q;
        blink_on_d = blink_on_q;
        if (cancel) begin
            state_d = IDLE;
        end else if (show_err) begin
            state_d    = ERR;
            hold_d     = '0;
            blink_d    = '0;
            blink_on_d = 1'b1;
        end else if (show_open) begin
            state_d = OPEN;
            hold_d  = '0;
        end else if (scan_tick && (state_q != IDLE)) begin
            if (hold_q == HOLD_MAX) begin
                state_d = IDLE;
                hold_d  = '0;
            end else begin
                hold_d = hold_q + 1'b1;
            end
            if (state_q == ERR) begin
                if (blink_q == BLINK_MAX) begin
                    blink_d    = '0;
                    blink_on_d = ~blink_on_q;
                end else begin
                    blink_d = blink_q + 1'b1;
                end
            end
        end
    end

    // FSM state and hold/blink counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            blink_q    <= '0;
            blink_on_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            blink_q    <= blink_d;
            blink_on_q <= blink_on_d;
        end
    end

    // Pin values: glyph for the current digit (blanked on the tick cycle), one-hot common, busy.
    always_comb begin
        seg_d = scan_tick ? GLY_BLANK : glyph_for(state_q, 32'(idx_q), blink_on_q);
        com_d = COM_IDLE;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (32'(idx_q) == d) begin
                com_d[d] = ~COM_ACT_LOW;
            end
        end
        busy_d = (state_q != IDLE);
    end

    // Output registers driving the board pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q  <= GLY_BLANK;
            com_q  <= COM_IDLE;
            busy_q <= 1'b0;
        end else begin
            seg_q  <= seg_d;
            com_q  <= com_d;
            busy_q <= busy_d;
        end
    end

    assign seg  = seg_q;
    assign com  = com_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_seg_msg_scan.sv
// Self-checking bench for seg_msg_scan with a tick-level behavioural reference model.
module tb_seg_msg_scan;

    localparam int unsigned ND = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned HS = 8;
    localparam int unsigned BS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          show_open = 1'b0;
    logic          show_err = 1'b0;
    logic          cancel = 1'b0;
    logic [6:0]    seg;
    logic [ND-1:0] com;
    logic          busy;

    int unsigned checks = 0;
    int unsigned errors = 0;

    seg_msg_scan #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .HOLD_SCANS  (HS),
        .BLINK_SCANS (BS),
        .COM_ACT_LOW (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .show_open (show_open),
        .show_err  (show_err),
        .cancel    (cancel),
        .seg       (seg),
        .com       (com),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: message text per digit, taken from the display rules.
    logic [6:0] open_txt [4] = '{7'b1111110, 7'b1100111, 7'b1001111, 7'b0010101};
    logic [6:0] err_txt  [4] = '{7'b1001111, 7'b0000101, 7'b0000101, 7'b0000000};

    // Model state: cycles since reset, message kind (0 none, 1 open, 2 err), ticks since message start.
    int unsigned m_cyc = 0;
    int unsigned m_kind = 0;
    int unsigned m_n = 0;
    logic [6:0]    exp_seg = '0;
    logic [ND-1:0] exp_com = '0;
    logic          exp_busy = 1'b0;

    function automatic logic model_tick(int unsigned cyc);
        return (cyc % SD) == (SD - 1);
    endfunction

    function automatic int unsigned model_digit(int unsigned cyc);
        return (cyc / SD) % ND;
    endfunction

    function automatic logic [6:0] model_seg(int unsigned cyc, int unsigned kind, int unsigned n);
        int unsigned d;
        d = model_digit(cyc);
        if (model_tick(cyc)) return 7'b0;
        if (kind == 1) return open_txt[d];
        if (kind == 2 && ((n / BS) % 2) == 0) return err_txt[d];
        return 7'b0;
    endfunction

    // Model advance: pins follow the pre-edge model state one cycle later.
    always @(posedge clk) begin
        if (rst) begin
            m_cyc    <= 0;
            m_kind   <= 0;
            m_n      <= 0;
            exp_seg  <= '0;
            exp_com  <= '0;
            exp_busy <= 1'b0;
        end else begin
            exp_seg  <= model_seg(m_cyc, m_kind, m_n);
            exp_com  <= ND'(1 << model_digit(m_cyc));
            exp_busy <= (m_kind != 0);
            m_cyc    <= m_cyc + 1;
            if (cancel) begin
                m_kind <= 0;
            end else if (show_err) begin
                m_kind <= 2;
                m_n    <= 0;
            end else if (show_open) begin
                m_kind <= 1;
                m_n    <= 0;
            end else if (model_tick(m_cyc) && m_kind != 0) begin
                m_n <= m_n + 1;
                if (m_n + 1 == HS) m_kind <= 0;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({seg, com, busy} !== {7'b0, 4'b0000, 1'b0}) begin
                errors++;
                $display("FAIL reset_vals: seg=%b com=%b busy=%b want seg=0000000 com=0000 busy=0", seg, com, busy);
            end
        end
        rst = 1'b0;
        repeat (64) begin
            @(negedge clk);
            checks++;
            if ({seg, com, busy} !== {exp_seg, exp_com, exp_busy}) begin
                errors++;
                $display("FAIL idle_scan: seg=%b com=%b busy=%b want seg=%b com=%b busy=%b", seg, com, busy, exp_seg, exp_com, exp_busy);
            end
        end
    endtask

    task automatic test_open();
        show_open = 1'b1;
        @(negedge clk);
        show_open = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL open_busy_rise: busy=%b want 1", busy);
        end
        repeat (40) begin
            @(negedge clk);
            checks++;
            if ({seg, com, busy} !== {exp_seg, exp_com, exp_busy}) begin
                errors++;
                $display("FAIL open_msg: seg=%b com=%b busy=%b want seg=%b com=%b busy=%b", seg, com, busy, exp_seg, exp_com, exp_busy);
            end
        end
        checks++;
        if ({seg, busy} !== {7'b0, 1'b0}) begin
            errors++;
            $display("FAIL open_expired: seg=%b busy=%b want seg=0000000 busy=0", seg, busy);
        end
    endtask

    task automatic test_err();
        show_err = 1'b1;
        @(negedge clk);
        show_err = 1'b0;
        repeat (44) begin
            @(negedge clk);
            checks++;
            if ({seg, com, busy} !== {exp_seg, exp_com, exp_busy}) begin
                errors++;
                $display("FAIL err_blink: seg=%b com=%b busy=%b want seg=%b com=%b busy=%b", seg, com, busy, exp_seg, exp_com, exp_busy);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL err_expired: busy=%b want 0", busy);
        end
    endtask

    task automatic test_both_then_open();
        bit found;
        show_open = 1'b1;
        show_err  = 1'b1;
        @(negedge clk);
        show_open = 1'b0;
        show_err  = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            checks++;
            if ({seg, com, busy} !== {exp_seg, exp_com, exp_busy}) begin
                errors++;
                $display("FAIL both_err_wins: seg=%b com=%b busy=%b want seg=%b com=%b busy=%b", seg, com, busy, exp_seg, exp_com, exp_busy);
            end
            if (m_kind == 2 && m_n == 6) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL both_wait_tick6: reached=0 want 1");
        end
        show_open = 1'b1;
        @(negedge clk);
        show_open = 1'b0;
        repeat (40) begin
            @(negedge clk);
            checks++;
            if ({seg, com, busy} !== {exp_seg, exp_com, exp_busy}) begin
                errors++;
                $display("FAIL err_to_open: seg=%b com=%b busy=%b want seg=%b com=%b busy=%b", seg, com, busy, exp_seg, exp_com, exp_busy);
            end
        end
    endtask

    task automatic test_cancel();
        show_open = 1'b1;
        @(negedge clk);
        show_open = 1'b0;
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        @(negedge clk);
        checks++;
        if ({seg, busy} !== {7'b0, 1'b0}) begin
            errors++;
            $display("FAIL cancel_blank: seg=%b busy=%b want seg=0000000 busy=0", seg, busy);
        end
        repeat (12) begin
            @(negedge clk);
            checks++;
            if ({seg, com, busy} !== {exp_seg, exp_com, exp_busy}) begin
                errors++;
                $display("FAIL cancel_scan: seg=%b com=%b busy=%b want seg=%b com=%b busy=%b", seg, com, busy, exp_seg, exp_com, exp_busy);
            end
        end
    endtask

    task automatic test_reset_mid_err();
        bit found;
        show_err = 1'b1;
        @(negedge clk);
        show_err = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (m_kind == 2 && ((m_n / BS) % 2) == 1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_wait_blink_off: reached=0 want 1");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({seg, com, busy} !== {7'b0, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_err: seg=%b com=%b busy=%b want seg=0000000 com=0000 busy=0", seg, com, busy);
        end
        show_err = 1'b1;
        @(negedge clk);
        show_err = 1'b0;
        repeat (40) begin
            @(negedge clk);
            checks++;
            if ({seg, com, busy} !== {exp_seg, exp_com, exp_busy}) begin
                errors++;
                $display("FAIL err_after_rst: seg=%b com=%b busy=%b want seg=%b com=%b busy=%b", seg, com, busy, exp_seg, exp_com, exp_busy);
            end
            if (com === 4'b0001 && busy === 1'b1 && seg !== 7'b0 && seg !== 7'b1001111) begin
                checks++;
                errors++;
                $display("FAIL err_first_glyph: seg=%b want 1001111", seg);
            end
        end
    endtask

    task automatic test_random();
        repeat (800) begin
            @(negedge clk);
            checks++;
            if ({seg, com, busy} !== {exp_seg, exp_com, exp_busy}) begin
                errors++;
                $display("FAIL random: seg=%b com=%b busy=%b want seg=%b com=%b busy=%b", seg, com, busy, exp_seg, exp_com, exp_busy);
            end
            show_open = ($urandom_range(23, 0) == 0);
            show_err  = ($urandom_range(29, 0) == 0);
            cancel    = ($urandom_range(59, 0) == 0);
            rst       = ($urandom_range(249, 0) == 0);
        end
        show_open = 1'b0;
        show_err  = 1'b0;
        cancel    = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        test_reset();
        test_open();
        test_err();
        test_both_then_open();
        test_cancel();
        test_reset_mid_err();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
